// File: rtl/encoder_4x2_pkg.sv
// ============================================================================
// Module : encoder_4x2_pkg
// Shared code constants and code type for the 4-to-2 priority encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package encoder_4x2_pkg;

  typedef logic [1:0] code_t;

  localparam code_t CODE_A = 2'b11;
  localparam code_t CODE_B = 2'b10;
  localparam code_t CODE_C = 2'b01;
  localparam code_t CODE_D = 2'b00;

endpackage

`default_nettype wire

// File: rtl/encoder_4x2_core.sv
// ============================================================================
// Module : encoder_4x2_core
// Combinational a>b>c>d priority encode with any-request and multi-hot flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module encoder_4x2_core
  import encoder_4x2_pkg::*;
(
  input  logic  a,
  input  logic  b,
  input  logic  c,
  input  logic  d,
  output code_t code,
  output logic  any,
  output logic  multi
);

  always_comb begin
    code = CODE_D;
    if (a)      code = CODE_A;
    else if (b) code = CODE_B;
    else if (c) code = CODE_C;
    else        code = CODE_D;
  end

  assign any   = a | b | c | d;
  // Two or more set is true exactly when some pair is set together.
  assign multi = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);

endmodule

`default_nettype wire

// File: rtl/encoder_4x2.sv
// ============================================================================
// Module : encoder_4x2
// Registered 4-to-2 priority encoder with valid, multi-hot flag and counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module encoder_4x2
  import encoder_4x2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             o1,
  output logic             o2,
  output logic             valid,
  output logic             multi,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  code_t w_code;
  logic  w_any;
  logic  w_multi;

  encoder_4x2_core u_core (
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .code  (w_code),
    .any   (w_any),
    .multi (w_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1    <= 1'b0;
      o2    <= 1'b0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else if (en) begin
      o1    <= w_code[1];
      o2    <= w_code[0];
      valid <= w_any;
      multi <= w_multi;
    end
  end

  // Clear takes precedence over increment and is honoured even when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (en && w_multi && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_encoder_4x2.sv
// ============================================================================
// Module : tb_encoder_4x2
// Self-checking bench: vector table, directed sequences and random stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_encoder_4x2;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr_cnt;
  logic             a, b, c, d;
  logic             o1, o2, valid, multi;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state, updated once per active edge from the input rules.
  int m_code  = 0;
  int m_valid = 0;
  int m_multi = 0;
  int m_cnt   = 0;

  typedef struct {
    logic [3:0] in;
    logic [1:0] code;
    logic       vld;
    logic       mlt;
  } vec_t;

  vec_t tbl [10];

  encoder_4x2 #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr_cnt (clr_cnt),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .o1      (o1),
    .o2      (o2),
    .valid   (valid),
    .multi   (multi),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_code(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] v, input logic e, input logic cl);
    int pc;
    pc = $countones(v);
    if (cl) m_cnt = 0;
    else if (e && pc >= 2 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    if (e) begin
      m_code  = ref_code(v);
      m_valid = (v != 4'b0000) ? 1 : 0;
      m_multi = (pc >= 2) ? 1 : 0;
    end
  endtask

  task automatic step(input logic [3:0] v, input logic e, input logic cl);
    {a, b, c, d} = v;
    en      = e;
    clr_cnt = cl;
    model_edge(v, e, cl);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".code"},  int'({o1, o2}), m_code);
    chk({tag, ".valid"}, int'(valid),    m_valid);
    chk({tag, ".multi"}, int'(multi),    m_multi);
    chk({tag, ".cnt"},   int'(err_cnt),  m_cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".code"},  int'({o1, o2}), 0);
    chk({tag, ".valid"}, int'(valid),    0);
    chk({tag, ".multi"}, int'(multi),    0);
    chk({tag, ".cnt"},   int'(err_cnt),  0);
  endtask

  initial begin
    tbl[0] = '{4'b0001, 2'b00, 1'b1, 1'b0};
    tbl[1] = '{4'b0010, 2'b01, 1'b1, 1'b0};
    tbl[2] = '{4'b0100, 2'b10, 1'b1, 1'b0};
    tbl[3] = '{4'b1000, 2'b11, 1'b1, 1'b0};
    tbl[4] = '{4'b0110, 2'b10, 1'b1, 1'b1};
    tbl[5] = '{4'b1111, 2'b11, 1'b1, 1'b1};
    tbl[6] = '{4'b0000, 2'b00, 1'b0, 1'b0};
    tbl[7] = '{4'b0011, 2'b01, 1'b1, 1'b1};
    tbl[8] = '{4'b1001, 2'b11, 1'b1, 1'b1};
    tbl[9] = '{4'b0101, 2'b10, 1'b1, 1'b1};

    rst_n = 1'b0; en = 1'b1; clr_cnt = 1'b0;
    {a, b, c, d} = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    rst_n = 1'b1;
    #2;

    foreach (tbl[i]) begin
      step(tbl[i].in, 1'b1, 1'b0);
      chk($sformatf("tbl%0d.code", i),  int'({o1, o2}), int'(tbl[i].code));
      chk($sformatf("tbl%0d.valid", i), int'(valid),    int'(tbl[i].vld));
      chk($sformatf("tbl%0d.multi", i), int'(multi),    int'(tbl[i].mlt));
      chk($sformatf("tbl%0d.cnt", i),   int'(err_cnt),  m_cnt);
    end

    // Hold while disabled, then resume.
    step(4'b1000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b0, 1'b0);
      chk("hold.code",  int'({o1, o2}), 3);
      chk("hold.valid", int'(valid),    1);
      check_all("hold");
    end
    step(4'b0001, 1'b1, 1'b0);
    chk("resume.code", int'({o1, o2}), 0);

    // Clear honoured while disabled.
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b1);
    chk("clr_dis.cnt", int'(err_cnt), 0);

    // Saturation and clear-over-increment.
    for (int k = 0; k < 300; k++) step(4'b0011, 1'b1, 1'b0);
    chk("sat.cnt", int'(err_cnt), CNT_MAX);
    step(4'b1100, 1'b1, 1'b0);
    chk("sat_hold.cnt", int'(err_cnt), CNT_MAX);
    step(4'b1111, 1'b1, 1'b1);
    chk("clr_win.cnt", int'(err_cnt), 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] v;
      logic       e, cl;
      v  = 4'($urandom_range(0, 15));
      e  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 15) == 0);
      step(v, e, cl);
      check_all("rand");
    end

    // Asynchronous reset between edges with code 11 and count 5.
    step(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step(4'b1001, 1'b1, 1'b0);
    chk("pre_rst.code", int'({o1, o2}), 3);
    chk("pre_rst.cnt",  int'(err_cnt),  5);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    m_code = 0; m_valid = 0; m_multi = 0; m_cnt = 0;
    {a, b, c, d} = 4'b1111; en = 1'b1; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst_held");
    rst_n = 1'b1;
    #2;
    step(4'b0100, 1'b1, 1'b0);
    check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
